// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg
//   Shared definitions for the buffered FIFO read end:
//   - default word / address widths,
//   - pointer width helper (address bits plus one wrap bit),
//   - empty / full compare helpers on wrap-bit pointers.
//   Helpers take zero-extended 32-bit pointers so one function serves every
//   parameterisation.
package fifo_rd_stream_pkg;

  localparam int DEF_FBITS = 8;
  localparam int DEF_ABITS = 4;

  // Pointer carries one extra MSB to tell a full buffer from an empty one.
  function automatic int ptr_width(input int ab);
    return ab + 1;
  endfunction

  // Empty: both pointers identical, including the wrap bit.
  function automatic logic ptr_empty(input logic [31:0] w, input logic [31:0] r);
    return (w == r);
  endfunction

  // Full: address fields equal, wrap bits differ.
  function automatic logic ptr_full(input logic [31:0] w, input logic [31:0] r,
                                    input int ab);
    logic [31:0] amask;
    logic [31:0] diff;
    amask = (32'd1 << ab) - 32'd1;
    diff  = w ^ r;
    return ((diff & amask) == 32'd0) && (((diff >> ab) & 32'd1) == 32'd1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_dpram.sv
// fifo_dpram
//   Simple dual-port RAM, 2**abits x fbits.
//   Ports:
//     clk   - write clock
//     we    - write enable
//     waddr - write address
//     wdata - write data
//     raddr - read address
//     rdata - read data, combinational from raddr
//   The read is asynchronous so the caller's output register can sample the
//   head word in the same cycle it decides to load. Contents are not reset.
module fifo_dpram #(
  parameter int fbits = 8,
  parameter int abits = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [abits-1:0] waddr,
  input  logic [fbits-1:0] wdata,
  input  logic [abits-1:0] raddr,
  output logic [fbits-1:0] rdata
);

  logic [fbits-1:0] mem [2**abits];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Buffered read end for the wr_fifo/data_in write interface. Words are
//   stored in a circular buffer of 2**abits entries and presented in order on
//   a first-word-fall-through valid/ready port through one output register.
//   Total capacity is 2**abits + 1 words.
//   Ports:
//     clk      - system clock
//     rst      - asynchronous active-high reset
//     clr_fifo - synchronous clear, dominates all other inputs
//     wr_fifo  - write strobe, accepted while full = 0
//     data_in  - write data
//     full     - buffer holds 2**abits words (registered)
//     rd_ready - consumer accepts data_out this cycle
//     rd_valid - data_out holds a valid word (registered)
//     data_out - head-of-queue word (registered)
//     level    - words in the buffer, not counting the output register
//     overflow - sticky: a write was attempted while full
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int fbits = DEF_FBITS,
  parameter int abits = DEF_ABITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_fifo,
  input  logic             wr_fifo,
  input  logic [fbits-1:0] data_in,
  output logic             full,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [fbits-1:0] data_out,
  output logic [abits:0]   level,
  output logic             overflow
);

  localparam int PW = ptr_width(abits);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [abits:0]   level_q, level_d;
  logic             full_q, full_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic [fbits-1:0] data_out_q, data_out_d;

  logic             empty;
  logic             wr_acc;
  logic             pop;
  logic             load;
  logic             ram_we;
  logic [fbits-1:0] ram_rdata;

  // Decisions use only state registered at the start of the cycle, so a
  // write into an empty buffer cannot be loaded in the same cycle.
  assign empty  = ptr_empty(32'(wptr_q), 32'(rptr_q));
  assign wr_acc = wr_fifo && !full_q;
  assign pop    = rd_valid_q && rd_ready;
  assign load   = (!rd_valid_q || pop) && !empty;
  assign ram_we = wr_acc && !clr_fifo;

  fifo_dpram #(
    .fbits (fbits),
    .abits (abits)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr_q[abits-1:0]),
    .wdata (data_in),
    .raddr (rptr_q[abits-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    rd_valid_d = rd_valid_q;
    overflow_d = overflow_q;
    data_out_d = data_out_q;

    if (clr_fifo) begin
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      rd_valid_d = 1'b0;
      overflow_d = 1'b0;
      data_out_d = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + PW'(1);
      end
      // A write while full is lost even if a pop frees space this cycle.
      if (wr_fifo && full_q) begin
        overflow_d = 1'b1;
      end
      if (load) begin
        data_out_d = ram_rdata;
        rptr_d     = rptr_q + PW'(1);
        rd_valid_d = 1'b1;
      end else if (pop) begin
        rd_valid_d = 1'b0;
      end
      case ({wr_acc, load})
        2'b10:   level_d = level_q + (abits+1)'(1);
        2'b01:   level_d = level_q - (abits+1)'(1);
        default: level_d = level_q;
      endcase
    end

    // Registering the full flag from next-state pointers keeps it equal to
    // the compare of the registered pointers.
    full_d = ptr_full(32'(wptr_d), 32'(rptr_d), abits);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      data_out_q <= data_out_d;
    end
  end

  assign full     = full_q;
  assign rd_valid = rd_valid_q;
  assign data_out = data_out_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Directed bench for fifo_rd_stream (fbits=8, abits=4): a vector table for
//   single-word latency, hold and clear, then hand-written sequences for fill,
//   overflow, streaming with wrap and asynchronous reset.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_fifo = 1'b0;
  logic       wr_fifo = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       full;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [7:0] data_out;
  logic [4:0] level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  fifo_rd_stream #(.fbits(8), .abits(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_fifo (clr_fifo),
    .wr_fifo  (wr_fifo),
    .data_in  (data_in),
    .full     (full),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .data_out (data_out),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       wr;
    logic [7:0] din;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_dout;
    logic [4:0] exp_level;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [7:0] d,
                         input logic [4:0] l, input logic f, input logic o);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(v));
    chk({tag, ".data_out"}, 32'(data_out), 32'(d));
    chk({tag, ".level"},    32'(level),    32'(l));
    chk({tag, ".full"},     32'(full),     32'(f));
    chk({tag, ".overflow"}, 32'(overflow), 32'(o));
  endtask

  // Advance one clock and land 1 ns after the edge for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr_fifo = 1'b1;
    wr_fifo  = 1'b0;
    rd_ready = 1'b0;
    step();
    clr_fifo = 1'b0;
  endtask

  initial begin
    int exp_next;
    bit started;

    //            clr   wr    din    rdy   valid dout   level full  ovf
    vecs[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h7E, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h7E, 5'd0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h7E, 5'd0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

    // Reset state.
    #1 rst = 1'b1;
    #1;
    chk_all("reset", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;

    // Table: single-word latency, hold under backpressure, drain, clear.
    for (int i = 0; i < 9; i++) begin
      clr_fifo = vecs[i].clr;
      wr_fifo  = vecs[i].wr;
      data_in  = vecs[i].din;
      rd_ready = vecs[i].rdy;
      step();
      $display("vec %0d: clr=%0b wr=%0b din=%02h rdy=%0b -> valid=%0b dout=%02h level=%0d full=%0b ovf=%0b",
               i, vecs[i].clr, vecs[i].wr, vecs[i].din, vecs[i].rdy,
               rd_valid, data_out, level, full, overflow);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_dout,
              vecs[i].exp_level, vecs[i].exp_full, vecs[i].exp_ovf);
    end
    clr_fifo = 1'b0;
    wr_fifo  = 1'b0;

    // Fill 16 words with no reader: word 0 sits in the output register.
    do_clear();
    for (int i = 0; i < 16; i++) begin
      wr_fifo = 1'b1;
      data_in = 8'(i);
      step();
    end
    $display("fill16: valid=%0b dout=%02h level=%0d full=%0b", rd_valid, data_out, level, full);
    chk_all("fill16", 1'b1, 8'h00, 5'd15, 1'b0, 1'b0);
    data_in = 8'h10;
    step();
    $display("fill17: level=%0d full=%0b", level, full);
    chk_all("fill17", 1'b1, 8'h00, 5'd16, 1'b1, 1'b0);
    data_in = 8'h11;
    step();
    $display("fill18: level=%0d full=%0b ovf=%0b", level, full, overflow);
    chk_all("fill18", 1'b1, 8'h00, 5'd16, 1'b1, 1'b1);

    // Pop and write together while full: write lost, output advances.
    data_in  = 8'h55;
    rd_ready = 1'b1;
    step();
    wr_fifo = 1'b0;
    $display("popfull: valid=%0b dout=%02h level=%0d full=%0b ovf=%0b",
             rd_valid, data_out, level, full, overflow);
    chk_all("popfull", 1'b1, 8'h01, 5'd15, 1'b0, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      step();
      chk($sformatf("drain%0d.data_out", i), 32'(data_out), 32'(i));
      chk($sformatf("drain%0d.rd_valid", i), 32'(rd_valid), 32'd1);
    end
    step();
    $display("drained: valid=%0b level=%0d", rd_valid, level);
    chk("drained.rd_valid", 32'(rd_valid), 32'd0);
    chk("drained.data_out", 32'(data_out), 32'h10);

    // Continuous stream of 40 words through a wrapping buffer.
    do_clear();
    rd_ready = 1'b1;
    exp_next = 0;
    started  = 1'b0;
    for (int cyc = 0; cyc < 60 && exp_next < 40; cyc++) begin
      wr_fifo = (cyc < 40);
      data_in = 8'(cyc);
      step();
      if (rd_valid) begin
        $display("stream: word=%02h", data_out);
        chk($sformatf("stream%0d", exp_next), 32'(data_out), 32'(exp_next));
        exp_next++;
        started = 1'b1;
      end else if (started) begin
        chk($sformatf("stream_gap_c%0d", cyc), 32'(rd_valid), 32'd1);
      end
    end
    wr_fifo = 1'b0;
    chk("stream_count", 32'(exp_next), 32'd40);

    // Clear with valid output, level 5 and a concurrent write.
    do_clear();
    for (int i = 0; i < 6; i++) begin
      wr_fifo = 1'b1;
      data_in = 8'(8'h20 + 8'(i));
      step();
    end
    chk("preclr.level", 32'(level), 32'd5);
    chk("preclr.rd_valid", 32'(rd_valid), 32'd1);
    clr_fifo = 1'b1;
    data_in  = 8'hEE;
    step();
    clr_fifo = 1'b0;
    wr_fifo  = 1'b0;
    $display("clr: valid=%0b dout=%02h level=%0d full=%0b ovf=%0b",
             rd_valid, data_out, level, full, overflow);
    chk_all("clr", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges, then a single write.
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_fifo = 1'b1;
      data_in = 8'(8'h40 + 8'(i));
      step();
    end
    wr_fifo = 1'b0;
    chk("prerst.rd_valid", 32'(rd_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("async rst: valid=%0b dout=%02h level=%0d", rd_valid, data_out, level);
    chk_all("arst", 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    wr_fifo = 1'b1;
    data_in = 8'h9A;
    step();
    wr_fifo = 1'b0;
    chk_all("arst_w1", 1'b0, 8'h00, 5'd1, 1'b0, 1'b0);
    step();
    $display("after rst write: valid=%0b dout=%02h", rd_valid, data_out);
    chk_all("arst_w2", 1'b1, 8'h9A, 5'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
